// File: rtl/intersection_phase_scheduler_pkg.sv
// Shared types and default timing for the intersection phase scheduler.
// Package name: traffic_pkg. Optional feature macro: PED_WALK_EN (adds the
// pedestrian walk phase).
package traffic_pkg;

    // Width of the per-phase tick counter
    localparam int CNT_W = 6;

    // Default phase timings, in ticks
    localparam int unsigned DEF_MAX_GREEN = 15;
    localparam int unsigned DEF_MIN_GREEN = 4;
    localparam int unsigned DEF_YELLOW_T  = 1;
    localparam int unsigned DEF_ALLRED_T  = 1;
    localparam int unsigned DEF_WALK_T    = 4;

`ifdef PED_WALK_EN
    typedef enum logic [2:0] {
        NS_GREEN, NS_YELLOW, AR1, EW_GREEN, EW_YELLOW, AR2, PED_WALK
    } state_e;
`else
    typedef enum logic [2:0] {
        NS_GREEN, NS_YELLOW, AR1, EW_GREEN, EW_YELLOW, AR2
    } state_e;
`endif

endpackage

// File: rtl/intersection_phase_scheduler_if.sv
// Sensor inputs and lamp outputs of the intersection phase scheduler.
// The master side (controller/bench) drives sensors; the slave side drives lamps.
interface intersection_phase_scheduler_if;

    logic tick;
    logic ns_req;
    logic ew_req;
    logic ped_req;
    logic ns_green;
    logic ns_yellow;
    logic ns_red;
    logic ew_green;
    logic ew_yellow;
    logic ew_red;
    logic walk;
    logic ped_ack;

    modport master (
        output tick, ns_req, ew_req, ped_req,
        input  ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red, walk, ped_ack
    );

    modport slave (
        input  tick, ns_req, ew_req, ped_req,
        output ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red, walk, ped_ack
    );

endinterface

// File: rtl/intersection_phase_scheduler_phase_timer.sv
// Per-phase tick counter: cleared on a phase change, counts ticks otherwise and
// saturates instead of wrapping. done marks the tick that completes dur ticks.
module phase_timer
    import traffic_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             clear,
    input  logic [CNT_W-1:0] dur,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear has priority over tick; hold at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (tick && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign done = tick && (cnt_q == dur - CNT_W'(1));

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Two-approach traffic phase scheduler with actuated gap-out on greens.
// Optional macro PED_WALK_EN inserts an all-red pedestrian walk phase after
// AR1/AR2 when a pedestrian request is pending.
module intersection_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int unsigned MAX_GREEN = DEF_MAX_GREEN,
    parameter int unsigned MIN_GREEN = DEF_MIN_GREEN,
    parameter int unsigned YELLOW_T  = DEF_YELLOW_T,
    parameter int unsigned ALLRED_T  = DEF_ALLRED_T,
    parameter int unsigned WALK_T    = DEF_WALK_T
) (
    input logic                            clk,
    input logic                            reset,
    intersection_phase_scheduler_if.slave  bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt, dur;
    logic             done, clear, gap_out;

    assign clear = (state_d != state_q);

    phase_timer u_timer (
        .clk   (clk),
        .reset (reset),
        .tick  (bus.tick),
        .clear (clear),
        .dur   (dur),
        .cnt   (cnt),
        .done  (done)
    );

    // Duration of the current phase; greens use it as the max-out point
    always_comb begin
        dur = CNT_W'(MAX_GREEN);
        unique case (state_q)
            NS_YELLOW, EW_YELLOW: dur = CNT_W'(YELLOW_T);
            AR1, AR2:             dur = CNT_W'(ALLRED_T);
`ifdef PED_WALK_EN
            PED_WALK:             dur = CNT_W'(WALK_T);
`endif
            default:              dur = CNT_W'(MAX_GREEN);
        endcase
    end

    // Gap-out is allowed once the minimum green has been served
    assign gap_out = bus.tick && (cnt >= CNT_W'(MIN_GREEN - 1));

`ifdef PED_WALK_EN
    logic ped_pend_q, ped_pend_d;
    logic ped_to_ew_q, ped_to_ew_d;
    logic ped_ack_q, ped_ack_d;
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
`ifdef PED_WALK_EN
        ped_pend_d  = ped_pend_q | bus.ped_req;
        ped_to_ew_d = ped_to_ew_q;
`endif
        unique case (state_q)
            NS_GREEN:
                if (done || (gap_out && !bus.ns_req && bus.ew_req)) state_d = NS_YELLOW;
            NS_YELLOW:
                if (done) state_d = AR1;
            AR1:
                if (done) state_d = EW_GREEN;
            EW_GREEN:
                if (done || (gap_out && !bus.ew_req && bus.ns_req)) state_d = EW_YELLOW;
            EW_YELLOW:
                if (done) state_d = AR2;
            AR2:
                if (done) state_d = NS_GREEN;
`ifdef PED_WALK_EN
            PED_WALK:
                if (done) state_d = ped_to_ew_q ? EW_GREEN : NS_GREEN;
`endif
            default: state_d = NS_GREEN;
        endcase
`ifdef PED_WALK_EN
        // Divert an all-red exit into the walk, remembering the green to resume
        if (done && ped_pend_q && (state_q == AR1 || state_q == AR2)) begin
            ped_to_ew_d = (state_q == AR1);
            state_d     = PED_WALK;
            // A request arriving on the acknowledge cycle stays pending
            ped_pend_d  = bus.ped_req;
        end
        ped_ack_d = (state_d == PED_WALK) && (state_q != PED_WALK);
`endif
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= NS_GREEN;
`ifdef PED_WALK_EN
            ped_pend_q  <= 1'b0;
            ped_to_ew_q <= 1'b0;
            ped_ack_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
`ifdef PED_WALK_EN
            ped_pend_q  <= ped_pend_d;
            ped_to_ew_q <= ped_to_ew_d;
            ped_ack_q   <= ped_ack_d;
`endif
        end
    end

    // Lamp decode from state only
    always_comb begin
        bus.ns_green  = (state_q == NS_GREEN);
        bus.ns_yellow = (state_q == NS_YELLOW);
        bus.ns_red    = !(state_q == NS_GREEN || state_q == NS_YELLOW);
        bus.ew_green  = (state_q == EW_GREEN);
        bus.ew_yellow = (state_q == EW_YELLOW);
        bus.ew_red    = !(state_q == EW_GREEN || state_q == EW_YELLOW);
`ifdef PED_WALK_EN
        bus.walk      = (state_q == PED_WALK);
        bus.ped_ack   = ped_ack_q;
`else
        bus.walk      = 1'b0;
        bus.ped_ack   = 1'b0;
`endif
    end

endmodule
